run_sequencer: RTL and testbench

Synthesizable run controller that replaces hand-written reset/run/finish sequencing around `system`. It drives the CPU reset for a parametrised number of clocks and counts clock cycles and instruction cycles (via `sync`). It ends a run on either a detected halt loop (PC unchanged across consecutive instruction cycles) or a cycle-budget timeout. Benches and the FPGA top both instantiate it between the clock/reset source and `system`.

---
 rtl/run_sequencer.sv | 140 ++++++++++++++
 tb/tb_run_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// run_sequencer: reset/run/finish controller placed in front of system.
// Holds CPU reset, counts cycles and instructions, stops on halt loop or timeout.
module run_sequencer #(
   parameter int RESET_CYCLES = 2,
   parameter int MAX_CYCLES   = 512,
   parameter int COUNT_WIDTH  = 32,
   parameter int ADDR_WIDTH   = 12,
   parameter int HALT_REPEATS = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   sync,
   input  logic [ADDR_WIDTH-1:0]  pc,
   output logic                   cpu_reset,
   output logic                   running,
   output logic                   done,
   output logic                   timeout,
   output logic [COUNT_WIDTH-1:0] cycle_count,
   output logic [COUNT_WIDTH-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_RUN,
      S_HALTED,
      S_TIMED_OUT
   } state_t;

   localparam logic [7:0]             HOLD_INIT = 8'(RESET_CYCLES);
   localparam logic [3:0]             HALT_LIM  = 4'(HALT_REPEATS);
   localparam logic [COUNT_WIDTH-1:0] MAX_C     = COUNT_WIDTH'(MAX_CYCLES);
   localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);

   state_t                 state;
   state_t                 state_nx;
   logic [7:0]             hold_cnt;
   logic [3:0]             rep_cnt;
   logic [3:0]             rep_nx;
   logic                   pc_valid;
   logic [ADDR_WIDTH-1:0]  last_pc;
   logic [COUNT_WIDTH-1:0] cyc_inc;
   logic [COUNT_WIDTH-1:0] instr_inc;
   logic                   pc_match;
   logic                   halt_hit;
   logic                   time_hit;
   logic                   launch;

   // saturating increments and end-of-run conditions for this clock
   always_comb begin
      cyc_inc   = (cycle_count == '1) ? cycle_count : cycle_count + ONE;
      instr_inc = (instr_count == '1) ? instr_count : instr_count + ONE;
      pc_match  = pc_valid && (pc == last_pc);
      rep_nx    = 4'd0;
      if (pc_match)
         rep_nx = (rep_cnt == 4'hF) ? rep_cnt : rep_cnt + 4'd1;
      halt_hit  = sync && (rep_nx >= HALT_LIM);
      time_hit  = (cyc_inc == MAX_C);
      launch    = start && (state == S_IDLE ||
                            state == S_HALTED ||
                            state == S_TIMED_OUT);
   end

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // next-state logic; abort overrides everything, halt beats timeout
   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:      if (start) state_nx = S_HOLD;
            S_HOLD:      if (hold_cnt <= 8'd1) state_nx = S_RUN;
            S_RUN: begin
               if (halt_hit)
                  state_nx = S_HALTED;
               else if (time_hit)
                  state_nx = S_TIMED_OUT;
            end
            S_HALTED:    if (start) state_nx = S_HOLD;
            S_TIMED_OUT: if (start) state_nx = S_HOLD;
            default:     state_nx = S_IDLE;
         endcase
      end
   end

   // status outputs decoded from the state register
   always_comb begin
      cpu_reset = 1'b1;
      running   = 1'b0;
      done      = 1'b0;
      timeout   = 1'b0;
      unique case (1'b1)
         (state == S_RUN):       begin cpu_reset = 1'b0; running = 1'b1; end
         (state == S_HALTED):    done    = 1'b1;
         (state == S_TIMED_OUT): timeout = 1'b1;
         default:                cpu_reset = 1'b1;
      endcase
   end

   // hold timer, counters and halt-loop detector; frozen while aborting
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold_cnt    <= 8'd0;
         rep_cnt     <= 4'd0;
         pc_valid    <= 1'b0;
         last_pc     <= '0;
         cycle_count <= '0;
         instr_count <= '0;
      end else if (!abort) begin
         if (launch) begin
            hold_cnt    <= HOLD_INIT;
            rep_cnt     <= 4'd0;
            pc_valid    <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
         end else if (state == S_HOLD) begin
            hold_cnt <= hold_cnt - 8'd1;
         end else if (state == S_RUN) begin
            cycle_count <= cyc_inc;
            if (sync) begin
               instr_count <= instr_inc;
               rep_cnt     <= rep_nx;
               last_pc     <= pc;
               pc_valid    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: randomized scenarios for run_sequencer.
// Expected results come from a sync-list model of halt/timeout rules.
module tb_run_sequencer;

   localparam int RC   = 2;
   localparam int MAXC = 512;
   localparam int HR   = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        sync  = 1'b0;
   logic [11:0] pc    = 12'h0;
   logic        cpu_reset;
   logic        running;
   logic        done;
   logic        timeout;
   logic [31:0] cycle_count;
   logic [31:0] instr_count;

   int n_pass  = 0;
   int n_total = 0;

   logic        sy_a [0:MAXC-1];
   logic [11:0] pc_a [0:MAXC-1];

   run_sequencer #(
      .RESET_CYCLES(RC),
      .MAX_CYCLES(MAXC),
      .COUNT_WIDTH(32),
      .ADDR_WIDTH(12),
      .HALT_REPEATS(HR)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .abort(abort),
      .sync(sync),
      .pc(pc),
      .cpu_reset(cpu_reset),
      .running(running),
      .done(done),
      .timeout(timeout),
      .cycle_count(cycle_count),
      .instr_count(instr_count)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // halt = first sync that closes a streak of HR+1 equal PCs;
   // otherwise the run ends on its last budgeted clock
   task automatic model(output int end_k, output int e_instr,
                        output bit e_done);
      int          streak;
      int          halt_k;
      logic [11:0] prev;
      streak = 0;
      halt_k = -1;
      prev   = 12'h0;
      for (int k = 0; k < MAXC && halt_k < 0; k++) begin
         if (sy_a[k]) begin
            if (streak > 0 && pc_a[k] == prev) streak++;
            else streak = 1;
            prev = pc_a[k];
            if (streak > HR) halt_k = k;
         end
      end
      e_done  = (halt_k >= 0);
      end_k   = e_done ? halt_k : MAXC - 1;
      e_instr = 0;
      for (int k = 0; k <= end_k; k++)
         if (sy_a[k]) e_instr++;
   endtask

   task automatic fill_clear();
      for (int k = 0; k < MAXC; k++) begin
         sy_a[k] = 1'b0;
         pc_a[k] = 12'($urandom);
      end
   endtask

   task automatic fill_periodic();
      for (int k = 0; k < MAXC; k++) begin
         sy_a[k] = (k % 8 == 0);
         pc_a[k] = 12'(k / 8);
      end
   endtask

   task automatic fill_sticky(input int first_sticky);
      int k;
      int n;
      fill_clear();
      k = $urandom_range(0, 3);
      n = 1;
      while (k < MAXC) begin
         sy_a[k] = 1'b1;
         pc_a[k] = (n >= first_sticky) ? 12'h0A5 : 12'(12'h200 + n * 3);
         n++;
         k += $urandom_range(1, 6);
      end
   endtask

   task automatic fill_random(input int pc_max, input int dens);
      for (int k = 0; k < MAXC; k++) begin
         sy_a[k] = ($urandom_range(0, dens - 1) == 0);
         pc_a[k] = 12'($urandom_range(0, pc_max));
      end
   endtask

   task automatic fill_coincide();
      fill_clear();
      for (int k = 0; k < 480; k += 10) begin
         sy_a[k] = 1'b1;
         pc_a[k] = 12'(12'h300 + k / 10);
      end
      for (int k = 495; k < MAXC; k += 4) begin
         sy_a[k] = 1'b1;
         pc_a[k] = 12'h0A5;
      end
   endtask

   task automatic run_sched(input string nm);
      int end_k;
      int e_instr;
      bit e_done;
      int w;
      int k;
      model(end_k, e_instr, e_done);
      start = 1'b1;
      tick();
      start = 1'b0;
      n_total++;
      if (cpu_reset !== 1'b1 || running !== 1'b0)
         $display("FAIL %s hold_entry got cpu_reset=%b running=%b expected 1/0",
                  nm, cpu_reset, running);
      else n_pass++;
      w = 0;
      while (running !== 1'b1 && w < 16) begin
         tick();
         w++;
      end
      n_total++;
      if (w !== RC || running !== 1'b1 || cpu_reset !== 1'b0)
         $display("FAIL %s hold_len got %0d expected %0d", nm, w, RC);
      else n_pass++;
      n_total++;
      if (cycle_count !== 32'd0 || instr_count !== 32'd0)
         $display("FAIL %s cleared got %0d/%0d expected 0/0",
                  nm, cycle_count, instr_count);
      else n_pass++;
      k = 0;
      while (running === 1'b1 && k < MAXC + 8) begin
         sync = (k < MAXC) ? sy_a[k] : 1'b0;
         pc   = (k < MAXC) ? pc_a[k] : 12'h0;
         tick();
         k++;
      end
      sync = 1'b0;
      n_total++;
      if (k !== end_k + 1)
         $display("FAIL %s run_len got %0d expected %0d", nm, k, end_k + 1);
      else n_pass++;
      n_total++;
      if (done !== e_done || timeout !== !e_done)
         $display("FAIL %s end_kind got done=%b timeout=%b expected done=%b",
                  nm, done, timeout, e_done);
      else n_pass++;
      n_total++;
      if (cycle_count !== 32'(end_k + 1))
         $display("FAIL %s cycle_count got %0d expected %0d",
                  nm, cycle_count, end_k + 1);
      else n_pass++;
      n_total++;
      if (instr_count !== 32'(e_instr))
         $display("FAIL %s instr_count got %0d expected %0d",
                  nm, instr_count, e_instr);
      else n_pass++;
      n_total++;
      if (cpu_reset !== 1'b1)
         $display("FAIL %s cpu_reset_end got %b expected 1", nm, cpu_reset);
      else n_pass++;
      repeat (4) begin
         sync = 1'($urandom);
         pc   = 12'($urandom);
         tick();
      end
      sync = 1'b0;
      n_total++;
      if (cycle_count !== 32'(end_k + 1) || instr_count !== 32'(e_instr) ||
          done !== e_done)
         $display("FAIL %s frozen got %0d/%0d expected %0d/%0d",
                  nm, cycle_count, instr_count, end_k + 1, e_instr);
      else n_pass++;
   endtask

   task automatic test_reset();
      tick();
      n_total++;
      if (cpu_reset !== 1'b1 || running !== 1'b0 ||
          done !== 1'b0 || timeout !== 1'b0)
         $display("FAIL reset_flags got %b%b%b%b expected 1000",
                  cpu_reset, running, done, timeout);
      else n_pass++;
      n_total++;
      if (cycle_count !== 32'd0 || instr_count !== 32'd0)
         $display("FAIL reset_counts got %0d/%0d expected 0/0",
                  cycle_count, instr_count);
      else n_pass++;
      reset = 1'b1;
      repeat (3) tick();
      n_total++;
      if (cpu_reset !== 1'b1 || running !== 1'b0)
         $display("FAIL idle_hold got cpu_reset=%b running=%b expected 1/0",
                  cpu_reset, running);
      else n_pass++;
   endtask

   task automatic test_start_timing();
      fill_random(4095, 5);
      run_sched("start_timing");
   endtask

   task automatic test_timeout();
      fill_periodic();
      run_sched("timeout_periodic");
      n_total++;
      if (timeout !== 1'b1 || cycle_count !== 32'd512 ||
          instr_count !== 32'd64)
         $display("FAIL timeout_const got %b/%0d/%0d expected 1/512/64",
                  timeout, cycle_count, instr_count);
      else n_pass++;
   endtask

   task automatic test_halt();
      fill_sticky(3);
      run_sched("halt_a5");
      n_total++;
      if (done !== 1'b1 || instr_count !== 32'd7)
         $display("FAIL halt_const got %b/%0d expected 1/7",
                  done, instr_count);
      else n_pass++;
      fill_sticky(1);
      run_sched("first_sync_no_repeat");
      n_total++;
      if (instr_count !== 32'd5)
         $display("FAIL first_sync instr got %0d expected 5", instr_count);
      else n_pass++;
   endtask

   task automatic test_coincide();
      fill_coincide();
      run_sched("halt_and_timeout");
      n_total++;
      if (done !== 1'b1 || timeout !== 1'b0 || cycle_count !== 32'd512)
         $display("FAIL coincide got done=%b timeout=%b cc=%0d expected 1/0/512",
                  done, timeout, cycle_count);
      else n_pass++;
   endtask

   task automatic test_abort();
      int w;
      int syncs;
      start = 1'b1;
      tick();
      start = 1'b0;
      w = 0;
      while (running !== 1'b1 && w < 16) begin
         tick();
         w++;
      end
      syncs = 0;
      for (int k = 0; k < 20; k++) begin
         sync  = (k % 3 == 0);
         pc    = 12'(k + 16);
         start = (k >= 5 && k < 10);
         if (sync) syncs++;
         tick();
      end
      start = 1'b0;
      sync  = 1'b0;
      n_total++;
      if (running !== 1'b1 || cycle_count !== 32'd20 ||
          instr_count !== 32'(syncs))
         $display("FAIL start_in_run got %b/%0d/%0d expected 1/20/%0d",
                  running, cycle_count, instr_count, syncs);
      else n_pass++;
      abort = 1'b1;
      start = 1'b1;
      sync  = 1'b1;
      pc    = 12'h7FF;
      tick();
      abort = 1'b0;
      start = 1'b0;
      sync  = 1'b0;
      n_total++;
      if (running !== 1'b0 || cpu_reset !== 1'b1 ||
          cycle_count !== 32'd20 || instr_count !== 32'(syncs))
         $display("FAIL abort got %b%b %0d/%0d expected 01 20/%0d",
                  running, cpu_reset, cycle_count, instr_count, syncs);
      else n_pass++;
      repeat (4) tick();
      n_total++;
      if (running !== 1'b0 || cpu_reset !== 1'b1 || cycle_count !== 32'd20)
         $display("FAIL abort_idle got running=%b cc=%0d expected 0/20",
                  running, cycle_count);
      else n_pass++;
      fill_random(4095, 4);
      run_sched("rerun_after_abort");
   endtask

   task automatic test_random();
      for (int i = 0; i < 5; i++) begin
         if (i % 2 == 0) fill_random(3, 3);
         else fill_random(63, 2);
         run_sched($sformatf("random_%0d", i));
      end
   endtask

   task automatic test_async_reset();
      int w;
      start = 1'b1;
      tick();
      start = 1'b0;
      w = 0;
      while (running !== 1'b1 && w < 16) begin
         tick();
         w++;
      end
      for (int k = 0; k < 10; k++) begin
         sync = 1'b1;
         pc   = 12'(k);
         tick();
      end
      sync = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      n_total++;
      if (cpu_reset !== 1'b1 || running !== 1'b0 ||
          cycle_count !== 32'd0 || instr_count !== 32'd0)
         $display("FAIL async_run got %b%b %0d/%0d expected 10 0/0",
                  cpu_reset, running, cycle_count, instr_count);
      else n_pass++;
      @(negedge clock);
      reset = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      n_total++;
      if (cpu_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0 ||
          timeout !== 1'b0 || cycle_count !== 32'd0)
         $display("FAIL async_hold got %b%b%b%b expected 1000",
                  cpu_reset, running, done, timeout);
      else n_pass++;
      @(negedge clock);
      reset = 1'b1;
      repeat (4) tick();
      n_total++;
      if (running !== 1'b0 || cpu_reset !== 1'b1)
         $display("FAIL async_idle got running=%b expected 0", running);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_start_timing();
      test_timeout();
      test_halt();
      test_coincide();
      test_abort();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
